fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_arbiter.sv | 151 +++++++++++++++
 tb/tb_fb_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter: address/pixel widths,
// the default framebuffer size and the clear-sequencer state encoding.
package fb_pkg;

    // 19 address bits cover 800x480 = 384000 words.
    localparam int FB_ADDR_W = 19;
    // Each framebuffer word is a 4-bit palette index.
    localparam int PIX_W = 4;
    // Project framebuffer size (800x480 words).
    localparam int FB_SIZE_DEFAULT = 384000;

    // Clear sequencer state.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;

endpackage : fb_pkg

// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: shares one single-port RAM between the scanout
// reader, an inline clear sequencer and the renderer write port.
// Priority per cycle is scanout read, then clear write, then renderer write.
module fb_arbiter
    import fb_pkg::*;
#(
    // FB_SIZE must stay below 2**FB_ADDR_W so that FB_SIZE itself is
    // representable in the 19-bit address compare.
    parameter int FB_SIZE = FB_SIZE_DEFAULT,
    parameter int DROP_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vga_req,
    input  logic [FB_ADDR_W-1:0] vga_addr,
    output logic [PIX_W-1:0]     vga_data,
    output logic                 vga_valid,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]     wr_data,
    input  logic                 clr_start,
    input  logic [PIX_W-1:0]     clr_index,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic                 mem_we,
    output logic [PIX_W-1:0]     mem_wdata,
    input  logic [PIX_W-1:0]     mem_rdata,
    output logic [DROP_W-1:0]    drop_count
);

    localparam logic [FB_ADDR_W-1:0] FB_END  = FB_ADDR_W'(FB_SIZE);
    localparam logic [FB_ADDR_W-1:0] FB_LAST = FB_ADDR_W'(FB_SIZE - 1);
    localparam logic [DROP_W-1:0]    DROP_MAX = '1;

    fb_state_e             state_q, state_d;
    logic [FB_ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic [PIX_W-1:0]      clr_idx_q, clr_idx_d;
    logic                  clr_done_q, clr_done_d;
    logic [DROP_W-1:0]     drop_q, drop_d;
    logic                  vga_valid_q, vga_valid_d;
    logic                  vga_inr_q, vga_inr_d;

    logic vga_hit;
    logic clr_wr;
    logic wr_fire;
    logic wr_inr;
    logic we_raw;

    // Request decode: who owns the RAM port this cycle.
    always_comb begin
        vga_hit  = vga_req && (vga_addr < FB_END);
        // Any scanout request, even out of range, stalls the clear pointer.
        clr_wr   = (state_q == ST_CLEAR) && !vga_req;
        wr_ready = (state_q == ST_IDLE) && !vga_req && !clr_start;
        wr_fire  = wr_valid && wr_ready;
        wr_inr   = wr_addr < FB_END;
    end

    // RAM port mux; write enable is forced low while reset is held.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        we_raw    = 1'b0;
        if (vga_hit) begin
            mem_addr = vga_addr;
        end else if (clr_wr) begin
            mem_addr  = clr_ptr_q;
            mem_wdata = clr_idx_q;
            we_raw    = 1'b1;
        end else if (wr_fire && wr_inr) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            we_raw    = 1'b1;
        end
        mem_we = we_raw && rst_n;
    end

    // Clear sequencer, drop counter and scanout return-path next state.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        clr_idx_d   = clr_idx_q;
        clr_done_d  = 1'b0;
        drop_d      = drop_q;
        vga_valid_d = vga_req;
        vga_inr_d   = vga_hit;

        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                    clr_idx_d = clr_index;
                end
            end
            ST_CLEAR: begin
                // clr_start is deliberately ignored here: no restart.
                if (clr_wr) begin
                    if (clr_ptr_q == FB_LAST) begin
                        state_d    = ST_IDLE;
                        clr_ptr_d  = '0;
                        clr_done_d = 1'b1;
                    end else begin
                        clr_ptr_d = clr_ptr_q + FB_ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_fire && !wr_inr && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // State registers; reset aborts any clear in progress without clr_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clr_ptr_q   <= '0;
            clr_idx_q   <= '0;
            clr_done_q  <= 1'b0;
            drop_q      <= '0;
            vga_valid_q <= 1'b0;
            vga_inr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            clr_idx_q   <= clr_idx_d;
            clr_done_q  <= clr_done_d;
            drop_q      <= drop_d;
            vga_valid_q <= vga_valid_d;
            vga_inr_q   <= vga_inr_d;
        end
    end

    // Outputs: RAM read data arrives one cycle after the address, so it is
    // passed straight through when the previous request was in range.
    always_comb begin
        vga_valid  = vga_valid_q;
        vga_data   = (vga_valid_q && vga_inr_q) ? mem_rdata : '0;
        clr_busy   = (state_q == ST_CLEAR);
        clr_done   = clr_done_q;
        drop_count = drop_q;
    end

endmodule : fb_arbiter

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a 16-word framebuffer and a 2-bit
// drop counter; a behavioural single-port RAM sits on the mem_* port.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vga_req;
    logic [18:0] vga_addr;
    logic [3:0]  vga_data;
    logic        vga_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [3:0]  wr_data;
    logic        clr_start;
    logic [3:0]  clr_index;
    logic        clr_busy;
    logic        clr_done;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;
    logic [1:0]  drop_count;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int oob_cnt = 0;

    logic [3:0] ram [0:15];

    fb_arbiter #(.FB_SIZE(16), .DROP_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_data(vga_data), .vga_valid(vga_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .clr_index(clr_index),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[3:0]];
    end

    // Event monitors: clr_done pulses and writes outside the framebuffer.
    always @(posedge clk) begin
        if (clr_done) done_cnt <= done_cnt + 1;
        if (mem_we && mem_addr >= 19'd16) oob_cnt <= oob_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got t=%0t want < 200000", $time);
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        vga_req = 1'b0; vga_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        clr_start = 1'b0; clr_index = '0;
    endtask

    task automatic do_write(input logic [18:0] a, input logic [3:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [18:0] a, output logic [3:0] d, output logic v);
        vga_req = 1'b1; vga_addr = a;
        tick();
        vga_req = 1'b0;
        #1;
        d = vga_data; v = vga_valid;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        wr_valid = 1'b1; wr_addr = 19'd3; wr_data = 4'h5;
        tick(); tick();
        #1;
        checks++;
        if (vga_valid !== 1'b0 || vga_data !== 4'h0) begin
            errors++; $display("FAIL reset_vga: got valid=%b data=%h want 0/0", vga_valid, vga_data);
        end
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0 || drop_count !== 2'd0) begin
            errors++; $display("FAIL reset_state: got busy=%b done=%b drop=%0d want 0/0/0", clr_busy, clr_done, drop_count);
        end
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we);
        end
        wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_write_read;
        logic [3:0] d; logic v;
        wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 4'hA;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'd5 || mem_wdata !== 4'hA) begin
            errors++; $display("FAIL wr_grant: got rdy=%b we=%b addr=%0d wdata=%h want 1/1/5/a", wr_ready, mem_we, mem_addr, mem_wdata);
        end
        tick();
        wr_valid = 1'b0;
        vga_req = 1'b1; vga_addr = 19'd5;
        #1;
        checks++;
        if (mem_addr !== 19'd5 || mem_we !== 1'b0 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL rd_grant: got addr=%0d we=%b rdy=%b want 5/0/0", mem_addr, mem_we, wr_ready);
        end
        tick();
        vga_req = 1'b0;
        #1;
        d = vga_data; v = vga_valid;
        checks++;
        if (v !== 1'b1 || d !== 4'hA) begin
            errors++; $display("FAIL write_then_read: got valid=%b data=%h want 1/a", v, d);
        end
        tick();
        checks++;
        if (vga_valid !== 1'b0) begin
            errors++; $display("FAIL valid_one_cycle: got %b want 0", vga_valid);
        end
        $display("test_write_read done");
    endtask

    task automatic test_collision;
        logic [3:0] d; logic v;
        vga_req = 1'b1; vga_addr = 19'd2;
        wr_valid = 1'b1; wr_addr = 19'd7; wr_data = 4'h6;
        #1;
        checks++;
        if (wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 19'd2) begin
            errors++; $display("FAIL collide_blocked: got rdy=%b we=%b addr=%0d want 0/0/2", wr_ready, mem_we, mem_addr);
        end
        tick();
        vga_req = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'd7 || vga_valid !== 1'b1) begin
            errors++; $display("FAIL collide_retry: got rdy=%b we=%b addr=%0d vvalid=%b want 1/1/7/1", wr_ready, mem_we, mem_addr, vga_valid);
        end
        tick();
        wr_valid = 1'b0;
        do_read(19'd7, d, v);
        checks++;
        if (v !== 1'b1 || d !== 4'h6) begin
            errors++; $display("FAIL collide_readback: got valid=%b data=%h want 1/6", v, d);
        end
        tick();
        $display("test_collision done");
    endtask

    task automatic test_clear_stalls;
        int d0, writes, busy, bad;
        logic [3:0] d; logic v;
        // clr_start wins over a simultaneous write.
        clr_start = 1'b1; clr_index = 4'h3;
        wr_valid = 1'b1; wr_addr = 19'd1; wr_data = 4'h9;
        #1;
        checks++;
        if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL clr_start_prio: got rdy=%b we=%b want 0/0", wr_ready, mem_we);
        end
        tick();
        clr_start = 1'b0; clr_index = 4'h0; wr_valid = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b1) begin
            errors++; $display("FAIL clr_busy_start: got %b want 1", clr_busy);
        end
        d0 = done_cnt; writes = 0; busy = 0; bad = 0;
        for (int c = 0; c < 100 && clr_busy === 1'b1; c++) begin
            vga_req = (c % 2 == 0);
            vga_addr = 19'(c & 15);
            #1;
            busy++;
            if (mem_we === 1'b1) begin
                if (mem_addr !== 19'(writes) || mem_wdata !== 4'h3) bad++;
                writes++;
            end
            tick();
        end
        vga_req = 1'b0;
        #1;
        checks++;
        if (busy != 32 || writes != 16 || bad != 0) begin
            errors++; $display("FAIL clear_stall_counts: got busy=%0d writes=%0d bad=%0d want 32/16/0", busy, writes, bad);
        end
        checks++;
        if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin
            errors++; $display("FAIL clr_done_pulse: got done=%b busy=%b want 1/0", clr_done, clr_busy);
        end
        tick();
        #1;
        checks++;
        if (clr_done !== 1'b0 || (done_cnt - d0) != 1) begin
            errors++; $display("FAIL clr_done_once: got done=%b pulses=%0d want 0/1", clr_done, done_cnt - d0);
        end
        for (int a = 0; a < 16; a++) begin
            do_read(19'(a), d, v);
            checks++;
            if (v !== 1'b1 || d !== 4'h3) begin
                errors++; $display("FAIL clear_readback[%0d]: got valid=%b data=%h want 1/3", a, v, d);
            end
        end
        tick();
        $display("test_clear_stalls done");
    endtask

    task automatic test_out_of_range;
        logic [3:0] d; logic v;
        wr_valid = 1'b1; wr_addr = 19'd16; wr_data = 4'hF;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL oob_write_grant: got rdy=%b we=%b want 1/0", wr_ready, mem_we);
        end
        tick();
        wr_valid = 1'b0;
        #1;
        checks++;
        if (drop_count !== 2'd1) begin
            errors++; $display("FAIL drop_count_1: got %0d want 1", drop_count);
        end
        vga_req = 1'b1; vga_addr = 19'd20;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL oob_read_we: got %b want 0", mem_we);
        end
        tick();
        vga_req = 1'b0;
        #1;
        d = vga_data; v = vga_valid;
        checks++;
        if (v !== 1'b1 || d !== 4'h0) begin
            errors++; $display("FAIL oob_read: got valid=%b data=%h want 1/0", v, d);
        end
        // Two more drops reach the 2-bit ceiling, a fourth must saturate.
        do_write(19'd17, 4'h1);
        do_write(19'h7FFFF, 4'h2);
        #1;
        checks++;
        if (drop_count !== 2'd3) begin
            errors++; $display("FAIL drop_count_3: got %0d want 3", drop_count);
        end
        do_write(19'd16, 4'h4);
        #1;
        checks++;
        if (drop_count !== 2'd3) begin
            errors++; $display("FAIL drop_saturate: got %0d want 3", drop_count);
        end
        do_read(19'd0, d, v);
        checks++;
        if (d !== 4'h3) begin
            errors++; $display("FAIL oob_no_alias: got word0=%h want 3", d);
        end
        tick();
        $display("test_out_of_range done");
    endtask

    task automatic test_clear_while_busy;
        int d0, writes, busy, bad;
        logic [3:0] d; logic v;
        do_write(19'd12, 4'hC);
        clr_start = 1'b1; clr_index = 4'h3;
        tick();
        clr_start = 1'b0;
        d0 = done_cnt; writes = 0; busy = 0; bad = 0;
        for (int c = 0; c < 100 && clr_busy === 1'b1; c++) begin
            clr_start = (c == 4);
            clr_index = (c == 4) ? 4'h9 : 4'h3;
            #1;
            busy++;
            if (mem_we === 1'b1) begin
                if (mem_wdata !== 4'h3) bad++;
                writes++;
            end
            tick();
        end
        clr_start = 1'b0;
        tick();
        #1;
        checks++;
        if (busy != 16 || writes != 16 || bad != 0) begin
            errors++; $display("FAIL restart_ignored: got busy=%0d writes=%0d bad=%0d want 16/16/0", busy, writes, bad);
        end
        checks++;
        if ((done_cnt - d0) != 1) begin
            errors++; $display("FAIL restart_done_once: got pulses=%0d want 1", done_cnt - d0);
        end
        do_read(19'd12, d, v);
        checks++;
        if (d !== 4'h3) begin
            errors++; $display("FAIL restart_readback: got %h want 3", d);
        end
        tick();
        $display("test_clear_while_busy done");
    endtask

    task automatic test_reset_mid_clear;
        int d0;
        logic [3:0] d; logic v;
        d0 = done_cnt;
        clr_start = 1'b1; clr_index = 4'h7;
        tick();
        clr_start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || mem_we !== 1'b0 || clr_done !== 1'b0) begin
            errors++; $display("FAIL mid_clear_reset: got busy=%b we=%b done=%b want 0/0/0", clr_busy, mem_we, clr_done);
        end
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || clr_busy !== 1'b0 || drop_count !== 2'd0) begin
            errors++; $display("FAIL after_release: got rdy=%b busy=%b drop=%0d want 1/0/0", wr_ready, clr_busy, drop_count);
        end
        tick(); tick();
        checks++;
        if ((done_cnt - d0) != 0) begin
            errors++; $display("FAIL mid_clear_no_done: got pulses=%0d want 0", done_cnt - d0);
        end
        do_read(19'd6, d, v);
        checks++;
        if (d !== 4'h7) begin
            errors++; $display("FAIL partial_clear_w6: got %h want 7", d);
        end
        do_read(19'd7, d, v);
        checks++;
        if (d !== 4'h3) begin
            errors++; $display("FAIL partial_clear_w7: got %h want 3", d);
        end
        tick();
        checks++;
        if (oob_cnt != 0) begin
            errors++; $display("FAIL stray_writes: got %0d oob writes want 0", oob_cnt);
        end
        $display("test_reset_mid_clear done");
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_write_read();
        test_collision();
        test_clear_stalls();
        test_out_of_range();
        test_clear_while_busy();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fb_arbiter
